div: RTL and testbench
======================

Name: div

Overview:
- Iterative signed 32-bit divider. It is the inverse companion of the Booth multiplier in the ALU/MULT-DIV unit and serves the MIPS `div` instruction.
- Takes dividend and divisor and produces quotient on `lo` and remainder on `hi`.
- One restoring-division step per clock, run by a small FSM with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, default 32, operand and result width. The iteration count equals WIDTH.

Ports:
- clk, input, 1: system clock, all state updates on posedge.
- reset, input, 1: synchronous, active-low. While 0 at a posedge the block is reset.
- start, input, 1: request pulse. Sampled only in IDLE.
- Dividendo, input, WIDTH: dividend (signed, two's complement). Sampled on the start edge.
- Divisor, input, WIDTH: divisor (signed). Sampled on the start edge.
- hi, output, WIDTH: remainder register.
- lo, output, WIDTH: quotient register.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: single-cycle pulse when hi/lo are valid and updated.
- div_zero, output, 1: sticky flag, set when the accepted operation had Divisor == 0.

Behaviour:
- Reset (reset == 0 at a posedge), from any state including mid-operation:
  - state goes to IDLE;
  - hi, lo = 0; busy, done, div_zero = 0;
  - iteration counter = 0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - done = 0.
  - On start == 1, capture |Dividendo| into the quotient shift register and |Divisor| into the divisor register.
  - Clear the partial remainder. Record q_neg = sign(Dividendo) XOR sign(Divisor) and r_neg = sign(Dividendo).
  - Load count = WIDTH. Clear div_zero. Go to RUN; busy = 1.
  - If Divisor == 0 at start: set div_zero = 1 and go to FINISH directly (skip RUN).
- RUN, each cycle:
  - Shift {R, Q} left by 1.
  - Compute T = R - D using a WIDTH+1-bit subtract.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise leave R unchanged and set Q[0] = 0.
  - Decrement count. When count reaches 0 after the decrement, go to FINISH.
- FINISH:
  - If div_zero: hi and lo keep their previous values.
  - Otherwise: lo = q_neg ? -Q : Q and hi = r_neg ? -R : R.
  - done = 1 for exactly this one cycle; busy = 0. Go to IDLE.
- Latency:
  - Normal operation: start sampled at edge E0; RUN on edges E1..E32; hi/lo written and done high after edge E33. done is asserted 33 cycles after the start edge.
  - Divide by zero: done after edge E1.
- Signed rules:
  - Truncating division: the quotient rounds toward zero and the remainder takes the sign of the dividend.
  - Absolute values are taken in WIDTH bits, so |0x80000000| is treated as unsigned 2^31.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000 (wraps) and hi = 0. No flag is raised.
- start while busy or in FINISH is ignored. Operands are not re-sampled.
- Operand inputs may change freely after the start edge.
- hi/lo hold their last result indefinitely in IDLE.
- Deassertion of reset resumes in IDLE on the next edge.

Decomposition:
- Shared package `div_pkg`:
  - state encoding localparams S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2;
  - WIDTH default;
  - counter width = $clog2(WIDTH) + 1.
- One combinational sub-module, `div_step`:
  - inputs R, Q, D;
  - outputs next R, next Q;
  - implements one shift/subtract/restore iteration.
- The FSM, counter, sign handling and output registers stay in `div`.

Test Plan:
- 7 / 2, start pulsed once → done pulses exactly 33 cycles after the start edge; lo = 3, hi = 1; busy high for 33 cycles.
- -7 (0xFFFFFFF9) / 2 → lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). Also check 7 / -2 → lo = 0xFFFFFFFD, hi = 1.
- 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, div_zero = 0. Also check 0x80000000 / 1 → lo = 0x80000000, hi = 0.
- Divide by zero:
  - First complete 100 / 7 (lo = 14, hi = 2).
  - Then run 5 / 0 → div_zero = 1 and done one cycle after start; hi = 2 and lo = 14 are unchanged.
- Reset mid-operation: start 1000 / 3, drive reset = 0 at the 10th RUN cycle → next cycle busy = 0, done = 0, hi = lo = 0. After release, 1000 / 3 completes with lo = 333, hi = 1.
- start held high for 40 cycles during 50 / 5 → exactly one operation is executed (lo = 10, hi = 0, one done pulse). A new operation starts only on the IDLE cycle after done.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative signed divider: default
//               operand width, FSM state encoding and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand / result width (iteration count equals this width)
    localparam int DIV_WIDTH = 32;

    // FSM state encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_RUN    = S_RUN,
        ST_FINISH = S_FINISH
    } state_t;

    // Iteration counter must hold the value WIDTH itself, hence the extra bit
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module      : div_if
// Description : Handshake and operand/result bundle between the control unit
//               (master) and the divider (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, Dividendo, Divisor,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, Dividendo, Divisor,
        output hi, lo, busy, done, div_zero
    );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration on unsigned magnitudes:
//               shift {R,Q} left, trial-subtract D, keep or restore R and
//               shift the resulting quotient bit into Q[0].
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  wire  [WIDTH-1:0] i_r,
    input  wire  [WIDTH-1:0] i_q,
    input  wire  [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    // Shifted remainder is kept WIDTH+1 wide so the trial subtract sign bit
    // is exact even when the divisor magnitude is 2^(WIDTH-1).
    logic [WIDTH:0]   w_r_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH:0]   w_diff;

    // Shift, trial subtract, then restore when the difference went negative
    always_comb begin
        w_r_sh = {i_r, i_q[WIDTH-1]};
        w_q_sh = {i_q[WIDTH-2:0], 1'b0};
        w_diff = w_r_sh - {1'b0, i_d};
        o_r    = w_r_sh[WIDTH-1:0];
        o_q    = w_q_sh;
        if (!w_diff[WIDTH]) begin
            o_r    = w_diff[WIDTH-1:0];
            o_q[0] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module      : div
// Description : Iterative signed divider for the MIPS div instruction.
//               Quotient on lo, remainder on hi, one restoring step per
//               clock with a start/busy/done handshake. Truncating division:
//               quotient rounds toward zero, remainder follows dividend sign.
// Revision    : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input wire   clk,
    input wire   reset,
    div_if.slave bus
);

    localparam int c_cnt_w = div_cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [c_cnt_w-1:0] r_count;

    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_zero;

    // Magnitudes in WIDTH bits: the most negative value maps to 2^(WIDTH-1)
    assign w_abs_a = bus.Dividendo[WIDTH-1] ? -bus.Dividendo : bus.Dividendo;
    assign w_abs_b = bus.Divisor[WIDTH-1]   ? -bus.Divisor   : bus.Divisor;
    assign w_zero  = (bus.Divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r (r_rem),
        .i_q (r_quo),
        .i_d (r_dvs),
        .o_r (w_rem_next),
        .o_q (w_quo_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a zero divisor skips the iteration phase entirely
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_zero ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == c_cnt_w'(1)) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_quo      <= w_abs_a;
                        r_dvs      <= w_abs_b;
                        r_rem      <= '0;
                        r_q_neg    <= bus.Dividendo[WIDTH-1] ^ bus.Divisor[WIDTH-1];
                        r_r_neg    <= bus.Dividendo[WIDTH-1];
                        r_count    <= c_cnt_w'(WIDTH);
                        r_busy     <= 1'b1;
                        r_div_zero <= w_zero;
                    end
                end
                ST_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count - c_cnt_w'(1);
                end
                ST_FINISH: begin
                    // A divide-by-zero leaves the previous result visible
                    if (!r_div_zero) begin
                        r_lo <= r_q_neg ? -r_quo : r_quo;
                        r_hi <= r_r_neg ? -r_rem : r_rem;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_div
// Description : Directed self-checking bench for the iterative signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div;
    import div_pkg::*;

    logic clk;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    div_if #(.WIDTH(32)) bus ();

    div #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, scramble the operands afterwards and wait
    // (bounded) for done; reports cycles from the start edge and busy cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int nbusy);
        bus.Dividendo = a;
        bus.Divisor   = b;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.Dividendo = $urandom;
        bus.Divisor   = $urandom;
        cyc   = 0;
        nbusy = 0;
        if (bus.busy) nbusy++;
        while (!bus.done && cyc < 100) begin
            tick();
            cyc++;
            if (bus.busy) nbusy++;
        end
        if (cyc >= 100) check("timeout", 32'(cyc), 32'd0);
    endtask

    initial begin
        int cyc;
        int nbusy;
        int ndone;
        int done_idx;
        logic [31:0] lo_at_done;
        logic [31:0] hi_at_done;
        logic busy_after;

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        repeat (3) tick();
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.div_zero), 32'd0);
        reset = 1'b1;
        tick();

        // 7 / 2 with latency and busy width
        run_op(32'd7, 32'd2, cyc, nbusy);
        check("7/2_lat",  32'(cyc), 32'd33);
        check("7/2_busy", 32'(nbusy), 32'd33);
        check("7/2_lo",   bus.lo, 32'd3);
        check("7/2_hi",   bus.hi, 32'd1);
        tick();
        check("7/2_done_pulse", 32'(bus.done), 32'd0);
        check("7/2_hold_lo", bus.lo, 32'd3);

        run_op(32'hFFFF_FFF9, 32'd2, cyc, nbusy);
        check("-7/2_lo", bus.lo, 32'hFFFF_FFFD);
        check("-7/2_hi", bus.hi, 32'hFFFF_FFFF);

        run_op(32'd7, 32'hFFFF_FFFE, cyc, nbusy);
        check("7/-2_lo", bus.lo, 32'hFFFF_FFFD);
        check("7/-2_hi", bus.hi, 32'd1);

        // Divide by zero keeps the previous result
        run_op(32'd100, 32'd7, cyc, nbusy);
        check("100/7_lo", bus.lo, 32'd14);
        check("100/7_hi", bus.hi, 32'd2);
        check("100/7_dz", 32'(bus.div_zero), 32'd0);
        run_op(32'd5, 32'd0, cyc, nbusy);
        check("5/0_lat", 32'(cyc), 32'd1);
        check("5/0_dz",  32'(bus.div_zero), 32'd1);
        check("5/0_lo",  bus.lo, 32'd14);
        check("5/0_hi",  bus.hi, 32'd2);
        tick();
        check("5/0_dz_sticky", 32'(bus.div_zero), 32'd1);

        // Overflow and most-negative dividend
        run_op(32'h8000_0000, 32'hFFFF_FFFF, cyc, nbusy);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'd0);
        check("ovf_dz", 32'(bus.div_zero), 32'd0);
        run_op(32'h8000_0000, 32'd1, cyc, nbusy);
        check("min/1_lo", bus.lo, 32'h8000_0000);
        check("min/1_hi", bus.hi, 32'd0);

        // Reset at the 10th iteration edge
        bus.Dividendo = 32'd1000;
        bus.Divisor   = 32'd3;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        tick();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_hi",   bus.hi, 32'd0);
        check("midrst_lo",   bus.lo, 32'd0);
        reset = 1'b1;
        tick();
        check("postrst_busy", 32'(bus.busy), 32'd0);
        run_op(32'd1000, 32'd3, cyc, nbusy);
        check("1000/3_lat", 32'(cyc), 32'd33);
        check("1000/3_lo",  bus.lo, 32'd333);
        check("1000/3_hi",  bus.hi, 32'd1);

        // start held for 40 edges: one done in the window, restart only on
        // the IDLE edge right after done
        bus.Dividendo = 32'd50;
        bus.Divisor   = 32'd5;
        bus.start     = 1'b1;
        ndone      = 0;
        done_idx   = -1;
        lo_at_done = '0;
        hi_at_done = '1;
        busy_after = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) begin
                ndone++;
                done_idx   = i;
                lo_at_done = bus.lo;
                hi_at_done = bus.hi;
            end
            if (i == 34) busy_after = bus.busy;
        end
        bus.start = 1'b0;
        check("held_ndone",    32'(ndone), 32'd1);
        check("held_done_idx", 32'(done_idx), 32'd33);
        check("held_lo",       lo_at_done, 32'd10);
        check("held_hi",       hi_at_done, 32'd0);
        check("held_restart",  32'(busy_after), 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("held_second_lo", bus.lo, 32'd10);
        tick();
        check("held_idle_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
